// File: rtl/par_to_serial_tx.sv
// -----------------------------------------------------------------------------
// par_to_serial_tx
//
// Transmit-side serializer for the one-bit link, clocked at the 32f bit rate.
// Every 8-bit frame slot carries either a valid data byte or the COMMA
// character, shifted out MSB first with no gap bits between frames. After
// reset the block sends N_SYNC commas so the receiver can lock its frame
// alignment, then enters RUN and starts accepting bytes from upstream.
//
// Handshake: load_req is high for the one clk_32f cycle that precedes a
// frame-start edge while in RUN. On that edge the byte is captured if
// valid_in=1; if valid_in=0 a COMMA is sent instead. data_in/valid_in are
// ignored on all other edges. There is no back-pressure: upstream must have
// its byte ready whenever load_req is high.
//
// Ports:
//   clk_32f   in   1  bit-rate clock, rising edge active
//   reset     in   1  asynchronous, active-high reset
//   data_in   in   8  parallel byte, sampled only when load_req=1
//   valid_in  in   1  qualifies data_in, sampled only when load_req=1
//   load_req  out  1  frame-boundary request (combinational from registers)
//   data_out  out  1  registered serial bit stream
//   sync_done out  1  high once the block is in RUN; also the FSM state view
// -----------------------------------------------------------------------------
module par_to_serial_tx #(
    parameter logic [7:0] COMMA  = 8'hBC,
    parameter int         N_SYNC = 4,
    parameter int         SYNC_W = 3
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       load_req,
    output logic       data_out,
    output logic       sync_done
);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Value of sync_cnt on the frame-start edge that loads the last comma.
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(N_SYNC - 1);

    generate
        if (N_SYNC < 1 || (2 ** SYNC_W) < N_SYNC) begin : g_bad_params
            $error("par_to_serial_tx: need N_SYNC >= 1 and 2**SYNC_W >= N_SYNC");
        end
    endgenerate

    state_t            state;
    logic [2:0]        bit_cnt;
    logic [SYNC_W-1:0] sync_cnt;
    logic [7:0]        shift_reg;
    logic [7:0]        next_byte;
    logic              frame_start;

    assign frame_start = (bit_cnt == 3'd0);

    // Commas are forced during SYNC regardless of what upstream presents.
    assign next_byte = (state == RUN && valid_in) ? data_in : COMMA;

    // Only raised in RUN, so upstream is never asked for data during sync.
    assign load_req = (state == RUN) && frame_start;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            bit_cnt   <= 3'd0;
            sync_cnt  <= '0;
            shift_reg <= 8'd0;
            data_out  <= 1'b0;
            sync_done <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (frame_start) begin
                // MSB goes straight to the output flop; the other seven bits
                // wait in shift_reg, so the frame has no extra latency.
                data_out  <= next_byte[7];
                shift_reg <= {next_byte[6:0], 1'b0};
                if (state == SYNC) begin
                    sync_cnt <= sync_cnt + 1'b1;
                    if (sync_cnt == SYNC_LAST) begin
                        state     <= RUN;
                        sync_done <= 1'b1;
                    end
                end
            end else begin
                data_out  <= shift_reg[7];
                shift_reg <= {shift_reg[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_par_to_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_par_to_serial_tx
//
// Drives two instances in parallel from the same inputs: one with the default
// N_SYNC=4 and one with N_SYNC=1. The reference model numbers the edges since
// reset release and derives everything from that number: frame index =
// (edge-1)/8, a frame carries data only when its index >= N_SYNC and valid_in
// was high at its first edge, load_req is expected only ahead of such frame
// starts, and sync_done from edge 8*(N_SYNC-1)+1 on. Expected serial bits are
// queued MSB first per frame and popped one per edge.
// -----------------------------------------------------------------------------
module tb_par_to_serial_tx;

    localparam logic [7:0] COMMA = 8'hBC;

    // ---------------- clock / reset ----------------
    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic [1:0] load_req_v;
    logic [1:0] data_out_v;
    logic [1:0] sync_done_v;

    always #5 clk_32f = ~clk_32f;

    par_to_serial_tx #(.COMMA(COMMA), .N_SYNC(4), .SYNC_W(3)) u_dut (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .load_req (load_req_v[0]),
        .data_out (data_out_v[0]),
        .sync_done(sync_done_v[0])
    );

    par_to_serial_tx #(.COMMA(COMMA), .N_SYNC(1), .SYNC_W(1)) u_dut1 (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .load_req (load_req_v[1]),
        .data_out (data_out_v[1]),
        .sync_done(sync_done_v[1])
    );

    // ---------------- scoreboard ----------------
    int n_sync [2] = '{4, 1};
    logic [0:0] exp_q0[$];
    logic [0:0] exp_q1[$];
    int edge_cnt = 0;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t edge %0d: got %0h expected %0h",
                     tag, $time, edge_cnt, got, exp);
        end
    endtask

    // Model bookkeeping for one upcoming edge; sampled values are those held
    // by the bench right before the edge.
    task automatic step();
        int         k;
        bit         fs;
        logic [7:0] b;
        logic [0:0] e;
        k  = edge_cnt + 1;
        fs = ((k - 1) % 8) == 0;
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("load_req[%0d]", d), 32'(load_req_v[d]),
                      32'(fs && (k > 8 * n_sync[d])));
            if (fs) begin
                b = (((k - 1) / 8) >= n_sync[d] && valid_in) ? data_in : COMMA;
                for (int i = 7; i >= 0; i--) begin
                    if (d == 0) exp_q0.push_back(b[i]);
                    else        exp_q1.push_back(b[i]);
                end
            end
        end
        @(posedge clk_32f);
        #1;
        edge_cnt = k;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check_val($sformatf("data_out[%0d]", d), 32'(data_out_v[d]), 32'(e));
            check_val($sformatf("sync_done[%0d]", d), 32'(sync_done_v[d]),
                      32'(k >= 8 * (n_sync[d] - 1) + 1));
        end
        @(negedge clk_32f);
    endtask

    // ---------------- driver tasks ----------------
    // Asserted between edges; the asynchronous clear must show at once.
    task automatic apply_reset();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("rst_data_out[%0d]", d), 32'(data_out_v[d]), 32'd0);
            check_val($sformatf("rst_load_req[%0d]", d), 32'(load_req_v[d]), 32'd0);
            check_val($sformatf("rst_sync_done[%0d]", d), 32'(sync_done_v[d]), 32'd0);
        end
        repeat (3) @(negedge clk_32f);
        check_val("rst_hold_data_out", 32'(data_out_v[0]), 32'd0);
        reset = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        edge_cnt = 0;
    endtask

    task automatic align_frame();
        while ((edge_cnt % 8) != 0) step();
    endtask

    // Hold one byte for a whole frame; optionally swap data_in mid-frame.
    task automatic send_frame(input logic v, input logic [7:0] d,
                              input bit swap, input logic [7:0] d2);
        align_frame();
        valid_in = v;
        data_in  = d;
        for (int i = 0; i < 8; i++) begin
            if (swap && i == 3) data_in = d2;
            step();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        @(negedge clk_32f);
        apply_reset();

        // Sync phase with idle input, then idle commas in RUN.
        valid_in = 1'b0;
        repeat (40) step();

        // Back-to-back data, then idle.
        send_frame(1'b1, 8'hFF, 1'b0, 8'h00);
        send_frame(1'b1, 8'hEE, 1'b0, 8'h00);
        send_frame(1'b1, 8'hDD, 1'b0, 8'h00);
        send_frame(1'b0, 8'h00, 1'b0, 8'h00);

        // Mid-frame change ignored; 55 goes out on the next load.
        send_frame(1'b1, 8'hAA, 1'b1, 8'h55);
        send_frame(1'b1, 8'h55, 1'b0, 8'h00);

        // COMMA as valid data goes out verbatim.
        send_frame(1'b1, COMMA, 1'b0, 8'h00);

        // Data presented during sync must not leak before RUN.
        apply_reset();
        for (int f = 0; f < 5; f++) send_frame(1'b1, 8'hAA, 1'b0, 8'h00);

        // Random inputs that change on every cycle, including mid-frame.
        for (int i = 0; i < 240; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = 8'($urandom_range(0, 255));
            step();
        end

        // Reset in the middle of a data frame, then full resync.
        align_frame();
        valid_in = 1'b1;
        data_in  = 8'hFF;
        repeat (4) step();
        apply_reset();
        valid_in = 1'b1;
        data_in  = 8'h3C;
        repeat (48) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/par_to_serial_tx.md
Name: par_to_serial_tx

Overview:
- Transmit-side serializer that feeds the serial-to-parallel receiver over the one-bit link, running at the 32f bit rate.
- Each 8-bit frame slot carries either a valid data byte or the COMMA character (0xBC); bits go out MSB first.
- After reset, the block sends N_SYNC commas before accepting data, so the receiver can lock its frame alignment.
- Upstream parallel logic is paced by a one-cycle load request issued at every frame boundary.

Parameters:
- COMMA, 8'hBC, idle/alignment character sent when no valid data is presented.
- N_SYNC, 4, number of commas sent after reset before data is accepted; must be >= 1.
- SYNC_W, 3, width of the sync frame counter; must satisfy 2**SYNC_W >= N_SYNC.

Ports:
- clk_32f  input  1  bit-rate clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset; the block has one clock (clk_32f).
- data_in  input  8  parallel byte; sampled only on edges where load_req=1.
- valid_in  input  1  qualifies data_in; sampled only on edges where load_req=1.
- load_req  output  1  frame-boundary request; combinational from registers.
- data_out  output  1  registered serial bit stream to the receiver.
- sync_done  output  1  high once the block is in RUN.

Behaviour:
- Reset (async, reset=1):
  - state=SYNC, bit_cnt=0, sync_cnt=0, shift_reg=0.
  - Outputs: data_out=0, load_req=0, sync_done=0.
  - Reset asserted mid-frame aborts the frame immediately; no partial byte is completed.
- bit_cnt is 3 bits and increments on every edge, wrapping 7->0. An edge where bit_cnt==0 is a frame-start edge.
- next_byte = (state==RUN && valid_in) ? data_in : COMMA.
- Frame-start edge:
  - data_out <= next_byte[7].
  - shift_reg <= {next_byte[6:0],1'b0}.
- Other edges:
  - data_out <= shift_reg[7].
  - shift_reg <= shift_reg<<1.
- Latency and bit order:
  - The MSB of the captured byte is on data_out right after the frame-start edge.
  - The LSB follows 7 edges later; each bit is held for exactly one clk_32f period.
  - Frames are back-to-back with no gap bits.
- State machine:
  - SYNC:
    - Sends COMMA regardless of valid_in; load_req=0.
    - On each frame-start edge, sync_cnt increments.
    - On the frame-start edge that loads comma number N_SYNC (sync_cnt==N_SYNC-1), state <= RUN.
  - RUN:
    - load_req = (bit_cnt==0).
    - On that edge, captures data_in if valid_in=1, otherwise sends COMMA.
    - Stays in RUN until reset.
  - sync_done = (state==RUN), registered.
- First-frame timing after reset release:
  - Edge 1 starts comma #1.
  - The first RUN frame starts at edge 8*N_SYNC+1, i.e. edge 33 with defaults.
  - sync_done rises after edge 8*(N_SYNC-1)+1 (edge 25).
- Boundary conditions:
  - valid_in=1 with data_in==COMMA: sent verbatim. The link cannot distinguish it from idle; this is an upstream responsibility.
  - data_in/valid_in changing while load_req=0: ignored, no effect on the frame in flight.
  - Reset released coincident with a clock edge: that edge is not counted; counting starts at the next edge.

Test Plan:
- Reset held 3 cycles, then released, valid_in=0 throughout -> data_out=0 and sync_done=0 during reset; then 1,0,1,1,1,1,0,0 repeated continuously; load_req=0 for edges 1-32; load_req pulses first at edge 33, then every 8 edges.
- After sync, valid_in=1 with data_in=FF, EE, DD on three consecutive load_req edges -> serial 11111111 11101110 11011101, followed by COMMA when valid_in drops to 0.
- valid_in=1 with data_in=AA asserted only during SYNC (edges 1-32) -> only commas are sent; AA is sent only if still presented at edge 33.
- data_in toggled to 55 mid-frame (load_req=0) while AA is being sent -> data_out stays 10101010; 55 is sent only if present at the next load_req.
- Reset pulsed at bit 4 of a data frame -> data_out=0 immediately; after release, the full N_SYNC=4 comma sequence is sent again before sync_done=1.
- N_SYNC=1 override -> sync_done after edge 1, load_req first at edge 9, and the first data byte's MSB appears after edge 9.
